flash_write_ctrl: RTL and testbench
===================================

# flash_write_ctrl

Memory-mapped flash write controller. It is the transmit counterpart of the flash/ADC acquisition peripheral. The CPU loads up to DEPTH 16-bit words over the IO write bus and issues a start command. The block then streams the words to the external flash with a one-cycle strobe per word, pacing on the flash busy flag. When the last word is sent it raises Interrupt_en, which stays high until the CPU writes the acknowledge address.

## Interface
- DEPTH, 16: buffer capacity in words; power of two, 2..256
- START_ADDR, 16'h6000: IO address that starts transmission
- ACK_ADDR, 16'h6001: IO address that clears the interrupt
- DATA_ADDR, 16'h6002: IO address that loads one word into the buffer

Ports:
- clock  in  1  single system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- Write_IO  in  1  CPU IO write strobe; level, may stay high for several cycles
- Adress_bus  in  16  CPU IO address
- Data_bus  in  16  CPU write data
- flash_busy  in  1  flash cannot accept a word while high
- FLASH_data  out  16  word presented to flash; registered
- put_data  out  1  one-cycle strobe, FLASH_data valid; registered
- Interrupt_en  out  1  transfer complete; level until acknowledged
- words_left  out  $clog2(DEPTH)+1  words still to send; 0 in IDLE

## Operation
- Command detection:
  - wr_evt = Write_IO & ~Write_IO_q, where Write_IO_q is Write_IO registered.
  - An address is acted on only on wr_evt, so a held Write_IO produces exactly one action.
- Buffer: DEPTH x 16 register array. Pointers wr_ptr and rd_ptr. count = number of words loaded.
- States:
  - IDLE
    - wr_evt to DATA_ADDR: if count < DEPTH, write buf[wr_ptr] = Data_bus, then wr_ptr++ and count++. If count == DEPTH, drop the word silently.
    - wr_evt to START_ADDR: if count > 0, go to SEND; if count == 0, go to DONE.
  - SEND
    - If flash_busy = 0: FLASH_data <= buf[rd_ptr], put_data <= 1, rd_ptr++, go to GAP.
    - If flash_busy = 1: hold state; no strobe.
  - GAP (exactly one cycle; gives the flash time to assert busy)
    - If rd_ptr == count, go to DONE; otherwise go to SEND.
  - DONE
    - Interrupt_en = 1.
    - wr_evt to ACK_ADDR: go to IDLE and clear wr_ptr, rd_ptr and count.
- Ignored events (no effect):
  - wr_evt to DATA_ADDR or START_ADDR outside IDLE.
  - wr_evt to ACK_ADDR outside DONE.
  - Any wr_evt to another address.
- Output values:
  - words_left = count − rd_ptr in SEND, GAP and DONE.
  - FLASH_data holds its last sent value between strobes.
- Widths:
  - Pointers and count are $clog2(DEPTH)+1 bits; no wrap occurs because count ≤ DEPTH.
  - Checksum arithmetic is modulo 2^16.

## Timing
- Reset values:
  - State IDLE.
  - FLASH_data = 0, put_data = 0, Interrupt_en = 0, words_left = 0.
  - Pointers and count = 0, Write_IO_q = 0.
- Reset mid-transfer: IDLE on the next edge, strobe stops immediately, buffer contents discarded.
- Start latency:
  - wr_evt sampled at edge N puts the state in SEND after N.
  - With flash_busy = 0, put_data is high for the cycle after edge N+1.
- Throughput: at most one word per 2 cycles.
- flash_busy is sampled only in SEND. A busy pulse during GAP has no effect.
- Interrupt_en rises on the edge that enters DONE:
  - one cycle after the last GAP;
  - one edge after the start wr_evt when the buffer is empty.
- Interrupt_en falls on the edge that samples the ACK wr_evt.
- Simultaneous events: a DATA_ADDR write on the same edge as a state change is judged by the current state, so it is dropped if the current state is not IDLE.

## Configuration
- FLASH_WR_CHECKSUM_EN defined:
  - The block keeps a 16-bit running sum of the words sent.
  - After the last data word it sends one extra word equal to the two's complement of that sum, using the same SEND/GAP pacing.
  - words_left counts the checksum word.
  - Sum modulo 2^16 of all transmitted words = 0.
  - Empty buffer plus START sends the single word 16'h0000, then DONE.
- Not defined: only data words are sent. Empty START goes directly to DONE with no strobe.

## Test plan
- Load 3 words (16'h1111, 16'h2222, 16'h3333) with Write_IO held 3 cycles each, then START, flash_busy = 0 -> exactly 3 put_data pulses 2 cycles apart carrying those values in order; Interrupt_en = 1 one cycle after the last GAP; a write to 16'h6001 clears it.
- Hold flash_busy = 1 for 10 cycles after START -> no put_data. The first strobe comes 1 cycle after busy falls. words_left stays 3 until then.
- Load DEPTH+2 words -> only the first DEPTH words are transmitted. The next DATA_ADDR write after ACK lands at buf[0].
- Write to DATA_ADDR and repeat START while in SEND -> ignored; word count and values unchanged. ACK while in SEND -> Interrupt_en stays 0 and transfer continues.
- Assert reset after the 2nd of 4 strobes -> all outputs zero next cycle. A new load of 1 word followed by START sends only that word.
- With FLASH_WR_CHECKSUM_EN, send 16'h0001 and 16'h0002 -> third strobe carries 16'hFFFD. Empty START -> one strobe of 16'h0000, then Interrupt_en.

Source files
------------

// File: rtl/flash_write_ctrl.sv
// flash_write_ctrl: memory-mapped flash write controller.
// The CPU loads up to DEPTH 16-bit words over the IO write bus, then issues
// a start command. Words are streamed to the flash one per strobe, paced by
// flash_busy, and Interrupt_en is raised when the buffer is drained. It stays
// high until the CPU writes the acknowledge address.
//
// Ports:
//   clock, reset       system clock; synchronous active-high reset
//   Write_IO           CPU IO write strobe (level; only its rising edge acts)
//   Adress_bus         CPU IO address
//   Data_bus           CPU write data
//   flash_busy         flash cannot accept a word while high
//   FLASH_data         registered word presented to the flash
//   put_data           registered one-cycle strobe qualifying FLASH_data
//   Interrupt_en       transfer complete, level until acknowledged
//   words_left         words still to send (0 in IDLE)
//
// Build option: define FLASH_WR_CHECKSUM_EN to append a two's-complement
// checksum word after the data words, so all sent words sum to 0 mod 2^16.

module flash_write_ctrl #(
    parameter int unsigned DEPTH      = 16,
    parameter logic [15:0] START_ADDR = 16'h6000,
    parameter logic [15:0] ACK_ADDR   = 16'h6001,
    parameter logic [15:0] DATA_ADDR  = 16'h6002
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     Write_IO,
    input  logic [15:0]              Adress_bus,
    input  logic [15:0]              Data_bus,
    input  logic                     flash_busy,
    output logic [15:0]              FLASH_data,
    output logic                     put_data,
    output logic                     Interrupt_en,
    output logic [$clog2(DEPTH):0]   words_left
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic           wr_io_q;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  count_q, count_d;
    logic [15:0]    flash_data_q, flash_data_d;
    logic           put_data_q, put_data_d;
    logic [15:0]    buf_q [DEPTH];
    logic           buf_we;

    logic           wr_evt;
    logic           is_data;
    logic           is_start;
    logic           is_ack;
    logic [PW-1:0]  total;
    logic [15:0]    send_word;
    logic [15:0]    rd_word;

    // Only the rising edge of Write_IO acts, so a held strobe is one command.
    assign wr_evt   = Write_IO & ~wr_io_q;
    assign is_data  = wr_evt && (Adress_bus == DATA_ADDR);
    assign is_start = wr_evt && (Adress_bus == START_ADDR);
    assign is_ack   = wr_evt && (Adress_bus == ACK_ADDR);

    assign rd_word  = buf_q[rd_ptr_q[AW-1:0]];

`ifdef FLASH_WR_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    // One extra slot after the data words carries the negated running sum.
    assign total     = count_q + PW'(1);
    assign send_word = (rd_ptr_q == count_q) ? 16'(16'h0000 - sum_q)
                                             : rd_word;
`else
    assign total     = count_q;
    assign send_word = rd_word;
`endif

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        flash_data_d = flash_data_q;
        put_data_d   = 1'b0;
        buf_we       = 1'b0;
`ifdef FLASH_WR_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (is_data) begin
                    // A full buffer drops further words silently.
                    if (count_q < DEPTH_W) begin
                        buf_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        count_d  = count_q + PW'(1);
                    end
                end else if (is_start) begin
`ifdef FLASH_WR_CHECKSUM_EN
                    // Even an empty buffer sends its checksum word.
                    state_d = S_SEND;
`else
                    state_d = (count_q != '0) ? S_SEND : S_DONE;
`endif
                end
            end
            S_SEND: begin
                if (!flash_busy) begin
                    flash_data_d = send_word;
                    put_data_d   = 1'b1;
                    rd_ptr_d     = rd_ptr_q + PW'(1);
                    state_d      = S_GAP;
`ifdef FLASH_WR_CHECKSUM_EN
                    sum_d        = sum_q + send_word;
`endif
                end
            end
            S_GAP: begin
                // One dead cycle lets the flash raise busy before the next word.
                state_d = (rd_ptr_q == total) ? S_DONE : S_SEND;
            end
            S_DONE: begin
                if (is_ack) begin
                    state_d  = S_IDLE;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
`ifdef FLASH_WR_CHECKSUM_EN
                    sum_d    = '0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_io_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            flash_data_q <= '0;
            put_data_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_io_q      <= Write_IO;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            flash_data_q <= flash_data_d;
            put_data_q   <= put_data_d;
        end
    end

`ifdef FLASH_WR_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    // Buffer contents need no reset: count gates what is ever read.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            buf_q[wr_ptr_q[AW-1:0]] <= Data_bus;
        end
    end

    assign FLASH_data   = flash_data_q;
    assign put_data     = put_data_q;
    assign Interrupt_en = (state_q == S_DONE);
    assign words_left   = (state_q == S_IDLE) ? '0 : (total - rd_ptr_q);

endmodule

// File: tb/tb_flash_write_ctrl.sv
// tb_flash_write_ctrl: directed self-checking bench for flash_write_ctrl.
// Cycle table for the basic transfer plus hand sequences for corner cases.

module tb_flash_write_ctrl;

    localparam int DEPTH = 16;
`ifdef FLASH_WR_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic        clk;
    logic        reset;
    logic        Write_IO;
    logic [15:0] Adress_bus;
    logic [15:0] Data_bus;
    logic        flash_busy;
    logic [15:0] FLASH_data;
    logic        put_data;
    logic        Interrupt_en;
    logic [4:0]  words_left;

    flash_write_ctrl #(.DEPTH(DEPTH)) dut (
        .clock       (clk),
        .reset       (reset),
        .Write_IO    (Write_IO),
        .Adress_bus  (Adress_bus),
        .Data_bus    (Data_bus),
        .flash_busy  (flash_busy),
        .FLASH_data  (FLASH_data),
        .put_data    (put_data),
        .Interrupt_en(Interrupt_en),
        .words_left  (words_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic        busy;
        logic        e_put;
        logic [15:0] e_fd;
        logic        e_int;
        logic [4:0]  e_wl;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] strobes[$];
    logic [15:0] expq[$];
    int          n_pass = 0;
    int          n_tot  = 0;

    always @(negedge clk) begin
        if (put_data) strobes.push_back(FLASH_data);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        Write_IO = 1'b1; Adress_bus = a; Data_bus = d;
        tick();
        Write_IO = 1'b0;
        tick();
    endtask

    task automatic wait_int();
        int k;
        k = 0;
        while (!Interrupt_en && k < 200) begin
            tick();
            k++;
        end
        chk("int_reached", {31'b0, Interrupt_en}, 32'd1);
    endtask

    // Appends the checksum word the DUT must send when that option is built in.
    task automatic add_ck();
        logic [15:0] s;
        s = 16'h0;
        foreach (expq[i]) s = s + expq[i];
        if (CK != 0) expq.push_back(16'(16'h0 - s));
    endtask

    task automatic check_stream(input string name);
        chk({name, "_cnt"}, strobes.size(), expq.size());
        for (int i = 0; i < expq.size() && i < strobes.size(); i++)
            chk({name, "_word"}, {16'b0, strobes[i]}, {16'b0, expq[i]});
    endtask

    function automatic vec_t v(input logic wr_, input logic [15:0] a,
                               input logic [15:0] d, input logic p,
                               input logic [15:0] fd, input logic it,
                               input int wl);
        vec_t r;
        r.wr = wr_; r.addr = a; r.data = d; r.busy = 1'b0;
        r.e_put = p; r.e_fd = fd; r.e_int = it; r.e_wl = 5'(wl);
        return r;
    endfunction

    initial begin
        int n;
        logic [15:0] w3[3];
        w3[0] = 16'h1111; w3[1] = 16'h2222; w3[2] = 16'h3333;

        // Basic transfer, one row per clock edge.
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++)
                tbl.push_back(v(1, 16'h6002, w3[i], 0, 16'h0, 0, 0));
            tbl.push_back(v(0, 16'h6002, w3[i], 0, 16'h0, 0, 0));
        end
        tbl.push_back(v(1, 16'h6000, 16'h0, 0, 16'h0,    0, 3 + CK));
        tbl.push_back(v(0, 16'h0,    16'h0, 1, 16'h1111, 0, 2 + CK));
        tbl.push_back(v(0, 16'h0,    16'h0, 0, 16'h1111, 0, 2 + CK));
        tbl.push_back(v(0, 16'h0,    16'h0, 1, 16'h2222, 0, 1 + CK));
        tbl.push_back(v(0, 16'h0,    16'h0, 0, 16'h2222, 0, 1 + CK));
        tbl.push_back(v(0, 16'h0,    16'h0, 1, 16'h3333, 0, 0 + CK));
`ifdef FLASH_WR_CHECKSUM_EN
        tbl.push_back(v(0, 16'h0,    16'h0, 0, 16'h3333, 0, 1));
        tbl.push_back(v(0, 16'h0,    16'h0, 1, 16'h999A, 0, 0));
        tbl.push_back(v(0, 16'h0,    16'h0, 0, 16'h999A, 1, 0));
        tbl.push_back(v(0, 16'h0,    16'h0, 0, 16'h999A, 1, 0));
        tbl.push_back(v(1, 16'h6001, 16'h0, 0, 16'h999A, 0, 0));
        tbl.push_back(v(0, 16'h0,    16'h0, 0, 16'h999A, 0, 0));
`else
        tbl.push_back(v(0, 16'h0,    16'h0, 0, 16'h3333, 1, 0));
        tbl.push_back(v(0, 16'h0,    16'h0, 0, 16'h3333, 1, 0));
        tbl.push_back(v(1, 16'h6001, 16'h0, 0, 16'h3333, 0, 0));
        tbl.push_back(v(0, 16'h0,    16'h0, 0, 16'h3333, 0, 0));
`endif

        reset = 1'b1; Write_IO = 1'b0; Adress_bus = '0;
        Data_bus = '0; flash_busy = 1'b0;
        tick(); tick();
        chk("rst_put", {31'b0, put_data}, 32'd0);
        chk("rst_fd", {16'b0, FLASH_data}, 32'd0);
        chk("rst_int", {31'b0, Interrupt_en}, 32'd0);
        chk("rst_wl", {27'b0, words_left}, 32'd0);
        reset = 1'b0;
        tick();

        foreach (tbl[i]) begin
            Write_IO = tbl[i].wr; Adress_bus = tbl[i].addr;
            Data_bus = tbl[i].data; flash_busy = tbl[i].busy;
            tick();
            chk($sformatf("tbl%0d_put", i), {31'b0, put_data}, {31'b0, tbl[i].e_put});
            chk($sformatf("tbl%0d_fd", i), {16'b0, FLASH_data}, {16'b0, tbl[i].e_fd});
            chk($sformatf("tbl%0d_int", i), {31'b0, Interrupt_en}, {31'b0, tbl[i].e_int});
            chk($sformatf("tbl%0d_wl", i), {27'b0, words_left}, {27'b0, tbl[i].e_wl});
        end
        Write_IO = 1'b0;
        tick();

        // Busy held after START: no strobe until it falls.
        strobes.delete(); expq.delete();
        wr(16'h6002, 16'hA1A1); wr(16'h6002, 16'hB2B2); wr(16'h6002, 16'hC3C3);
        expq.push_back(16'hA1A1); expq.push_back(16'hB2B2);
        expq.push_back(16'hC3C3); add_ck();
        flash_busy = 1'b1;
        Write_IO = 1'b1; Adress_bus = 16'h6000;
        tick();
        Write_IO = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("busy_noput", {31'b0, put_data}, 32'd0);
            chk("busy_wl", {27'b0, words_left}, 32'(3 + CK));
        end
        flash_busy = 1'b0;
        tick();
        chk("busy_first_put", {31'b0, put_data}, 32'd1);
        chk("busy_first_fd", {16'b0, FLASH_data}, 32'hA1A1);
        wait_int();
        check_stream("busy");
        wr(16'h6001, 16'h0);
        chk("busy_ack", {31'b0, Interrupt_en}, 32'd0);

        // Overflow: DEPTH+2 loads, only DEPTH sent.
        strobes.delete(); expq.delete();
        for (int i = 0; i < DEPTH + 2; i++) begin
            wr(16'h6002, 16'(16'h4000 + i));
            if (i < DEPTH) expq.push_back(16'(16'h4000 + i));
        end
        add_ck();
        wr(16'h6000, 16'h0);
        wait_int();
        check_stream("ovf");
        wr(16'h6001, 16'h0);
        strobes.delete(); expq.delete();
        wr(16'h6002, 16'h5555);
        expq.push_back(16'h5555); add_ck();
        wr(16'h6000, 16'h0);
        wait_int();
        check_stream("after_ack");
        wr(16'h6001, 16'h0);

        // Commands outside their state are ignored.
        strobes.delete(); expq.delete();
        wr(16'h6002, 16'h0A0A); wr(16'h6002, 16'h0B0B); wr(16'h6002, 16'h0C0C);
        expq.push_back(16'h0A0A); expq.push_back(16'h0B0B);
        expq.push_back(16'h0C0C); add_ck();
        flash_busy = 1'b1;
        wr(16'h6000, 16'h0);
        wr(16'h6002, 16'h9999);
        wr(16'h6000, 16'h0);
        wr(16'h6001, 16'h0);
        chk("ign_int", {31'b0, Interrupt_en}, 32'd0);
        chk("ign_wl", {27'b0, words_left}, 32'(3 + CK));
        wr(16'h7777, 16'h0);
        chk("ign_noput", 32'(strobes.size()), 32'd0);
        flash_busy = 1'b0;
        wait_int();
        check_stream("ign");
        wr(16'h6001, 16'h0);

        // Reset after the 2nd of 4 strobes.
        strobes.delete();
        for (int i = 0; i < 4; i++) wr(16'h6002, 16'(16'h1000 * (i + 1)));
        Write_IO = 1'b1; Adress_bus = 16'h6000;
        tick();
        Write_IO = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && n < 2; k++) begin
            tick();
            if (put_data) n++;
        end
        chk("rst2_seen", 32'(n), 32'd2);
        reset = 1'b1;
        tick();
        chk("rst2_put", {31'b0, put_data}, 32'd0);
        chk("rst2_fd", {16'b0, FLASH_data}, 32'd0);
        chk("rst2_int", {31'b0, Interrupt_en}, 32'd0);
        chk("rst2_wl", {27'b0, words_left}, 32'd0);
        reset = 1'b0;
        tick();
        strobes.delete(); expq.delete();
        wr(16'h6002, 16'h7777);
        expq.push_back(16'h7777); add_ck();
        wr(16'h6000, 16'h0);
        wait_int();
        check_stream("post_rst");
        wr(16'h6001, 16'h0);

`ifdef FLASH_WR_CHECKSUM_EN
        strobes.delete(); expq.delete();
        wr(16'h6002, 16'h0001); wr(16'h6002, 16'h0002);
        expq.push_back(16'h0001); expq.push_back(16'h0002);
        expq.push_back(16'hFFFD);
        wr(16'h6000, 16'h0);
        wait_int();
        check_stream("ck12");
        wr(16'h6001, 16'h0);
        strobes.delete(); expq.delete();
        expq.push_back(16'h0000);
        wr(16'h6000, 16'h0);
        wait_int();
        check_stream("ck_empty");
        wr(16'h6001, 16'h0);
`else
        strobes.delete();
        Write_IO = 1'b1; Adress_bus = 16'h6000;
        tick();
        chk("empty_int", {31'b0, Interrupt_en}, 32'd1);
        Write_IO = 1'b0;
        tick(); tick();
        chk("empty_noput", 32'(strobes.size()), 32'd0);
        wr(16'h6001, 16'h0);
        chk("empty_ack", {31'b0, Interrupt_en}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
